eight_bit_seq_divider: RTL and testbench

EIGHT_BIT_SEQ_DIVIDER -- requirements
Module: eight_bit_seq_divider

---
 rtl/eight_bit_seq_divider_pkg.sv | 16 +
 rtl/eight_bit_seq_divider_step.sv | 18 +
 rtl/eight_bit_seq_divider.sv | 121 ++++++++++++
 tb/tb_eight_bit_seq_divider.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/eight_bit_seq_divider_pkg.sv
// Shared types and constants for the sequential 16/8 restoring divider.
package eight_bit_seq_divider_pkg;
  localparam int DIVIDEND_W = 16;
  localparam int DIVISOR_W  = 8;
  localparam int QUOT_W     = 8;

  localparam logic [QUOT_W-1:0] OVF_VAL = 8'hFF;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  typedef struct packed {
    logic [QUOT_W-1:0]    quot;
    logic [DIVISOR_W-1:0] rem;
    logic                 ovf;
  } div_res_t;
endpackage

// File: rtl/eight_bit_seq_divider_step.sv
// One restoring division step: shift in a dividend bit, subtract divisor if it fits.
module div_restore_step
  import eight_bit_seq_divider_pkg::*;
(
  input  logic [DIVISOR_W:0]   r_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W:0]   r_o,
  output logic                 q_o
);
  logic [DIVISOR_W+1:0] shifted, diff;

  // Full-width shift keeps the compare exact even if r_i[8] were ever set.
  assign shifted = {r_i, bit_i};
  assign diff    = shifted - {2'b00, divisor_i};
  assign q_o     = (shifted >= {2'b00, divisor_i});
  assign r_o     = q_o ? diff[DIVISOR_W:0] : shifted[DIVISOR_W:0];
endmodule

// File: rtl/eight_bit_seq_divider.sv
// Sequential 16/8 unsigned restoring divider, ITER_PER_CYCLE steps per clock.
// Optional early termination (dividend==0 / divisor==1) under DIV_EARLY_TERM_EN.
module eight_bit_seq_divider
  import eight_bit_seq_divider_pkg::*;
#(
  parameter int ITER_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [QUOT_W-1:0]     quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  ovf
);
  localparam int STEPS = QUOT_W / ITER_PER_CYCLE;

  state_t                state_q, state_d;
  logic [DIVISOR_W:0]    rem_q, rem_d;
  logic [QUOT_W-1:0]     dlo_q, dlo_d;   // low dividend bits out the top, quotient bits in the bottom
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [3:0]            cnt_q, cnt_d;
  div_res_t              res_q, res_d;

  logic [ITER_PER_CYCLE:0][DIVISOR_W:0] r_chain;
  logic [ITER_PER_CYCLE-1:0]            q_bits;
  logic                                 ovf_c;

  assign r_chain[0] = rem_q;

  for (genvar i = 0; i < ITER_PER_CYCLE; i++) begin : g_step
    div_restore_step u_step (
      .r_i       (r_chain[i]),
      .bit_i     (dlo_q[QUOT_W-1-i]),
      .divisor_i (dvs_q),
      .r_o       (r_chain[i+1]),
      .q_o       (q_bits[ITER_PER_CYCLE-1-i])
    );
  end

  assign ovf_c = (divisor == '0) || (dividend[DIVIDEND_W-1:QUOT_W] >= divisor);

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    dlo_d     = dlo_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          dvs_d = divisor;
          rem_d = {1'b0, dividend[DIVIDEND_W-1:QUOT_W]};
          dlo_d = dividend[QUOT_W-1:0];
          cnt_d = '0;
          if (ovf_c) begin
            res_d   = '{quot: OVF_VAL, rem: OVF_VAL, ovf: 1'b1};
            state_d = DONE;
          end
`ifdef DIV_EARLY_TERM_EN
          else if (dividend == '0) begin
            res_d   = '{quot: '0, rem: '0, ovf: 1'b0};
            state_d = DONE;
          end else if (divisor == 8'd1) begin
            res_d   = '{quot: dividend[QUOT_W-1:0], rem: '0, ovf: 1'b0};
            state_d = DONE;
          end
`endif
          else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        rem_d = r_chain[ITER_PER_CYCLE];
        dlo_d = {dlo_q[QUOT_W-1-ITER_PER_CYCLE:0], q_bits};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(STEPS-1)) begin
          cnt_d   = '0;
          res_d   = '{quot: dlo_d, rem: r_chain[ITER_PER_CYCLE][DIVISOR_W-1:0], ovf: 1'b0};
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      dlo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dlo_q   <= dlo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign quotient  = res_q.quot;
  assign remainder = res_q.rem;
  assign ovf       = res_q.ovf;
endmodule

// File: tb/tb_eight_bit_seq_divider.sv
// Bench for eight_bit_seq_divider: instance 0 at ITER_PER_CYCLE=1, instance 1 at 2.
module tb_eight_bit_seq_divider;
  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       o;
    int         lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid_s [2];
  logic        in_ready_s [2];
  logic [15:0] dividend_s [2];
  logic [7:0]  divisor_s  [2];
  logic        out_valid_s[2];
  logic        out_ready_s[2];
  logic [7:0]  quotient_s [2];
  logic [7:0]  remainder_s[2];
  logic        ovf_s      [2];

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  eight_bit_seq_divider #(.ITER_PER_CYCLE(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .dividend(dividend_s[0]), .divisor(divisor_s[0]), .out_valid(out_valid_s[0]),
    .out_ready(out_ready_s[0]), .quotient(quotient_s[0]), .remainder(remainder_s[0]),
    .ovf(ovf_s[0]));

  eight_bit_seq_divider #(.ITER_PER_CYCLE(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .dividend(dividend_s[1]), .divisor(divisor_s[1]), .out_valid(out_valid_s[1]),
    .out_ready(out_ready_s[1]), .quotient(quotient_s[1]), .remainder(remainder_s[1]),
    .ovf(ovf_s[1]));

  function automatic exp_t model(input int d, input logic [15:0] dvd, input logic [7:0] dvs);
    exp_t e;
    int   a, b;
    a = int'(dvd);
    b = int'(dvs);
    if (b == 0 || (a / 256) >= b) begin
      e.q = 8'hFF; e.r = 8'hFF; e.o = 1'b1; e.lat = 1;
    end else begin
      e.q = 8'(a / b); e.r = 8'(a % b); e.o = 1'b0;
      e.lat = (d == 0) ? 9 : 5;
`ifdef DIV_EARLY_TERM_EN
      if (a == 0 || b == 1) e.lat = 1;
`endif
    end
    return e;
  endfunction

  // Drive one operation, hold out_ready low for 'hold' cycles in DONE, then drain.
  task automatic run_op(input int d, input logic [15:0] dvd, input logic [7:0] dvs, input int hold);
    exp_t e;
    int   lat;
    sb.push_back(model(d, dvd, dvs));
    @(negedge clk);
    dividend_s[d] = dvd; divisor_s[d] = dvs; in_valid_s[d] = 1'b1; out_ready_s[d] = 1'b0;
    checks++;
    if (in_ready_s[d] !== 1'b1) begin
      errors++; $display("FAIL idle_in_ready d%0d: got %b exp 1", d, in_ready_s[d]);
    end
    @(posedge clk); #1;
    in_valid_s[d] = 1'b0; dividend_s[d] = ~dvd; divisor_s[d] = ~dvs;
    lat = 1;
    while (out_valid_s[d] !== 1'b1 && lat < 40) begin
      if (in_ready_s[d] !== 1'b0) begin
        checks++; errors++; $display("FAIL calc_in_ready d%0d: got %b exp 0", d, in_ready_s[d]);
      end
      @(posedge clk); #1; lat++;
    end
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat) begin
      errors++; $display("FAIL latency d%0d %h/%h: got %0d exp %0d", d, dvd, dvs, lat, e.lat);
    end
    for (int c = 0; c <= hold; c++) begin
      checks++;
      if (quotient_s[d] !== e.q || remainder_s[d] !== e.r || ovf_s[d] !== e.o ||
          out_valid_s[d] !== 1'b1 || in_ready_s[d] !== 1'b0) begin
        errors++;
        $display("FAIL result d%0d %h/%h cyc%0d: got q=%h r=%h o=%b v=%b rdy=%b exp q=%h r=%h o=%b v=1 rdy=0",
                 d, dvd, dvs, c, quotient_s[d], remainder_s[d], ovf_s[d], out_valid_s[d],
                 in_ready_s[d], e.q, e.r, e.o);
      end
      if (c < hold) begin @(posedge clk); #1; end
    end
    out_ready_s[d] = 1'b1;
    @(posedge clk); #1;
    out_ready_s[d] = 1'b0;
    checks++;
    if (in_ready_s[d] !== 1'b1 || out_valid_s[d] !== 1'b0 || quotient_s[d] !== e.q ||
        remainder_s[d] !== e.r) begin
      errors++;
      $display("FAIL drain d%0d: got rdy=%b v=%b q=%h r=%h exp rdy=1 v=0 q=%h r=%h",
               d, in_ready_s[d], out_valid_s[d], quotient_s[d], remainder_s[d], e.q, e.r);
    end
  endtask

  task automatic check_zero(input string name);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (in_ready_s[d] !== 1'b1 || out_valid_s[d] !== 1'b0 || quotient_s[d] !== 8'h00 ||
          remainder_s[d] !== 8'h00 || ovf_s[d] !== 1'b0) begin
        errors++;
        $display("FAIL %s d%0d: got rdy=%b v=%b q=%h r=%h o=%b exp rdy=1 v=0 q=0 r=0 o=0",
                 name, d, in_ready_s[d], out_valid_s[d], quotient_s[d], remainder_s[d], ovf_s[d]);
      end
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      in_valid_s[d] = 1'b0; out_ready_s[d] = 1'b0; dividend_s[d] = '0; divisor_s[d] = '0;
    end
    rst_n = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check_zero("post_reset");
  endtask

  task automatic test_basic();
    run_op(0, 16'd1000, 8'd7, 0);
    run_op(0, 16'd0255, 8'd1, 0);
    run_op(0, 16'h0100, 8'h02, 0);
  endtask

  task automatic test_overflow();
    run_op(0, 16'h1234, 8'h00, 0);
    run_op(0, 16'hFFFE, 8'hFF, 0);
    run_op(0, 16'h0700, 8'h07, 0);
    run_op(0, 16'h0000, 8'h00, 0);
  endtask

  task automatic test_backpressure();
    run_op(0, 16'h00FF, 8'h10, 5);
  endtask

  task automatic test_early_term();
    run_op(0, 16'h0000, 8'd5, 0);
    run_op(0, 16'h00AB, 8'd1, 0);
    run_op(1, 16'h0000, 8'd5, 0);
    run_op(1, 16'h00AB, 8'd1, 0);
  endtask

  task automatic test_reset_abort();
    @(negedge clk);
    dividend_s[0] = 16'd1000; divisor_s[0] = 8'd7; in_valid_s[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("abort_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_zero("abort_release");
    for (int c = 0; c < 12; c++) begin
      checks++;
      if (out_valid_s[0] !== 1'b0) begin
        errors++; $display("FAIL abort_no_result cyc%0d: got v=%b exp 0", c, out_valid_s[0]);
      end
      @(posedge clk); #1;
    end
    run_op(0, 16'd50, 8'd5, 0);
  endtask

  task automatic test_iter2();
    run_op(1, 16'd1000, 8'd7, 0);
    run_op(1, 16'h00FF, 8'h10, 2);
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    logic [7:0]  b;
    for (int n = 0; n < 24; n++) begin
      b = 8'($urandom_range(1, 255));
      a = {8'($urandom_range(0, 255)) % b, 8'($urandom)};
      if (n % 6 == 5) a[15:8] = b;
      run_op(1, a, b, n % 3);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_early_term();
    test_reset_abort();
    test_iter2();
    test_back_to_back();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_empty: got %0d entries exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
